// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester handshake, status and serial line bundle for uart_tx_scheduler
// Signals: req0/req1 + frame0/frame1 (requesters -> scheduler), gnt0/gnt1 grant pulses,
//          busy/owner/done status and tx line (scheduler -> requesters/receiver).
interface uart_tx_scheduler_if #(parameter int W = 16);
   logic req0, req1, gnt0, gnt1, busy, owner, done, tx;
   logic [W-1:0] frame0, frame1;
   modport master (output req0, req1, frame0, frame1, input gnt0, gnt1, busy, owner, done, tx);
   modport slave (input req0, req1, frame0, frame1, output gnt0, gnt1, busy, owner, done, tx);
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter plus start/LSB-first data/stop/guard serializer sharing one tx line
// Ports: clk, rst (synchronous active-high); bus (slave modport) carries req0/frame0/gnt0 and
//        req1/frame1/gnt1 from the two requesters, and busy/owner/done/tx toward requesters and receiver.
module uart_tx_scheduler #(
   parameter int CLKS_PER_BIT = 3000,
   parameter int STEP = 0,
   parameter int MSG_SIZE = 6,
   parameter int GUARD_BITS = 2
) (
   input logic clk,
   input logic rst,
   uart_tx_scheduler_if.slave bus
);
   localparam int CODED_MSG_SIZE = 2*(MSG_SIZE+2*(2*STEP+1));
   localparam int CW = $clog2(CLKS_PER_BIT+1);
   localparam int BW = $clog2((CODED_MSG_SIZE > GUARD_BITS ? CODED_MSG_SIZE : GUARD_BITS)+1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, GUARD} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [BW-1:0] bit_idx, bit_n;
   logic [CODED_MSG_SIZE-1:0] shift, shift_n;
   logic ptr, ptr_n, owner_q, owner_n, gnt0_q, gnt0_n, gnt1_q, gnt1_n;
   logic tx_q, busy_q, done_q, pick1, last;
   assign bus.tx = tx_q;
   assign bus.gnt0 = gnt0_q;
   assign bus.gnt1 = gnt1_q;
   assign bus.busy = busy_q;
   assign bus.owner = owner_q;
   assign bus.done = done_q;
   assign last = cnt == CW'(CLKS_PER_BIT-1);
   // ptr remembers the requester served last; on a tie the other one wins
   assign pick1 = bus.req1 && !(bus.req0 && ptr);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
         ptr <= 1'b1;
         owner_q <= 1'b0;
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         tx_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         bit_idx <= bit_n;
         shift <= shift_n;
         ptr <= ptr_n;
         owner_q <= owner_n;
         gnt0_q <= gnt0_n;
         gnt1_q <= gnt1_n;
         // outputs are registered from next-state values so they line up with the state they describe
         tx_q <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
         busy_q <= state_n != IDLE;
         done_q <= cnt_n == CW'(CLKS_PER_BIT-1) &&
                   ((state_n == GUARD && bit_n == BW'(GUARD_BITS-1)) || (GUARD_BITS == 0 && state_n == STOP));
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = (state == IDLE || last) ? '0 : cnt + 1'b1;
      bit_n = bit_idx;
      shift_n = shift;
      ptr_n = ptr;
      owner_n = owner_q;
      gnt0_n = 1'b0;
      gnt1_n = 1'b0;
      case (state)
         IDLE: if (bus.req0 || bus.req1) begin
            state_n = START;
            shift_n = pick1 ? bus.frame1 : bus.frame0;
            ptr_n = pick1;
            owner_n = pick1;
            gnt0_n = !pick1;
            gnt1_n = pick1;
         end
         START: if (last) begin
            state_n = DATA;
            bit_n = '0;
         end
         DATA: if (last) begin
            shift_n = shift >> 1;
            state_n = bit_idx == BW'(CODED_MSG_SIZE-1) ? STOP : DATA;
            bit_n = bit_idx == BW'(CODED_MSG_SIZE-1) ? '0 : bit_idx + 1'b1;
         end
         STOP: if (last) begin
            state_n = GUARD_BITS == 0 ? IDLE : GUARD;
            bit_n = '0;
         end
         GUARD: if (last) begin
            state_n = bit_idx == BW'(GUARD_BITS-1) ? IDLE : GUARD;
            bit_n = bit_idx == BW'(GUARD_BITS-1) ? '0 : bit_idx + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and randomized checks of uart_tx_scheduler against a line-position reference model
module tb_uart_tx_scheduler;
   localparam int CPB = 4, N = 16, G = 2, L = N+2+G, T = L*CPB;
   logic clk = 1'b0, rst = 1'b1;
   int n_checks = 0, n_pass = 0, cyc_n = 0, n_done = 0;
   int g_own[$];
   bit auto_drop = 1'b1, rand_mode = 1'b0;
   bit m_valid, m_act, m_ptr, m_owner, m_n;
   int m_k;
   logic [L-1:0] m_line;
   logic [5:0] exp_o;
   uart_tx_scheduler_if #(.W(N)) b();
   uart_tx_scheduler #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(b));
   always #5 clk = ~clk;
   // reference: a granted frame is a line vector {guard ones, stop, data, start}; output cycle k shows bit k/CPB
   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1;
         m_act = 0;
         m_ptr = 1;
         m_owner = 0;
      end else if (m_act) begin
         m_k++;
         if (m_k == T) m_act = 0;
      end else if (b.req0 || b.req1) begin
         m_n = b.req1 && !(b.req0 && m_ptr);
         m_line = {{(G+1){1'b1}}, m_n ? b.frame1 : b.frame0, 1'b0};
         m_act = 1;
         m_k = 0;
         m_ptr = m_n;
         m_owner = m_n;
      end
      exp_o = {m_act && m_k == 0 && !m_owner, m_act && m_k == 0 && m_owner, m_act, m_owner,
               m_act && m_k == T-1, m_act ? m_line[m_k/CPB] : 1'b1};
   end
   task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_n);
   endtask
   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         cyc_n++;
         if (m_valid) check("cycle{gnt0,gnt1,busy,owner,done,tx}",
                            80'({b.gnt0, b.gnt1, b.busy, b.owner, b.done, b.tx}), 80'(exp_o));
         if (b.gnt0 || b.gnt1) g_own.push_back(int'(b.gnt1));
         if (b.done) n_done++;
         if (auto_drop) begin
            if (b.gnt0) b.req0 = 0;
            if (b.gnt1) b.req1 = 0;
         end
         if (rand_mode) begin
            if (!b.req0 && $urandom_range(0, 7) == 0) b.req0 = 1;
            if (!b.req1 && $urandom_range(0, 7) == 0) b.req1 = 1;
            if ($urandom_range(0, 3) == 0) b.frame0 = N'($urandom);
            if ($urandom_range(0, 3) == 0) b.frame1 = N'($urandom);
            rst = $urandom_range(0, 799) == 0;
         end
      end
   endtask
   task automatic wait_gnt(input bit which, input int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit && !ok; i++) begin
         step(1);
         ok = which ? b.gnt1 : b.gnt0;
      end
   endtask
   task automatic reset_dut();
      b.req0 = 0;
      b.req1 = 0;
      rst = 1;
      step(1);
      rst = 0;
   endtask
   task automatic grants_since(input int from, output int cnt, output logic [7:0] ord);
      cnt = g_own.size() - from;
      ord = '0;
      for (int i = 0; i < cnt && i < 8; i++) ord[i] = g_own[from+i] != 0;
   endtask
   initial begin
      logic [L-1:0] lit_line;
      logic [79:0] txv, dv, gv, e;
      logic [7:0] ord;
      bit ok;
      int t0, n0, d0, cnt;
      b.req0 = 0;
      b.req1 = 0;
      b.frame0 = '0;
      b.frame1 = '0;
      step(2);
      rst = 0;
      check("reset_outputs", 80'({b.gnt0, b.gnt1, b.busy, b.owner, b.done, b.tx}), 80'(6'b000001));
      // single frame, hand-written line pattern
      b.frame0 = 16'b0011101110001110;
      b.req0 = 1;
      wait_gnt(0, 20, ok);
      check("single_gnt0_seen", 80'(ok), 80'(1));
      lit_line = {3'b111, 16'b0011101110001110, 1'b0};
      for (int j = 0; j < T; j++) begin
         txv[j] = b.tx;
         dv[j] = b.done;
         gv[j] = b.gnt0;
         e[j] = lit_line[j/CPB];
         if (j < T-1) step(1);
      end
      check("single_tx_bits", txv, e);
      check("single_done_at_80", dv, 80'(1) << (T-1));
      check("single_gnt0_pulse", gv, 80'(1));
      step(3);
      // simultaneous requests after reset
      reset_dut();
      n0 = g_own.size();
      b.frame0 = 16'hAAAA;
      b.frame1 = 16'h5555;
      b.req0 = 1;
      b.req1 = 1;
      step(2*T+10);
      grants_since(n0, cnt, ord);
      check("simul_grant_count", 80'(cnt), 80'(2));
      check("simul_grant_order", 80'(ord), 80'(8'b10));
      check("simul_final_owner", 80'(b.owner), 80'(1));
      // fairness with both requests held
      reset_dut();
      auto_drop = 0;
      n0 = g_own.size();
      b.req0 = 1;
      b.req1 = 1;
      for (int i = 0; i < 6*T && g_own.size() - n0 < 4; i++) step(1);
      b.req0 = 0;
      b.req1 = 0;
      auto_drop = 1;
      grants_since(n0, cnt, ord);
      check("fair_grant_count", 80'(cnt), 80'(4));
      check("fair_grant_order", 80'(ord), 80'(8'b1010));
      step(T+5);
      // request while busy, frame0 changed mid-frame
      reset_dut();
      b.frame0 = 16'hC3A5;
      b.req0 = 1;
      wait_gnt(0, 20, ok);
      check("busy_gnt0_seen", 80'(ok), 80'(1));
      t0 = cyc_n;
      step(30);
      b.frame0 = 16'h3C5A;
      b.frame1 = 16'h0FF0;
      b.req1 = 1;
      wait_gnt(1, 2*T, ok);
      check("busy_gnt1_seen", 80'(ok), 80'(1));
      check("busy_gnt1_delay", 80'(cyc_n - t0), 80'(T+1));
      step(T+5);
      // reset during data bit 5
      reset_dut();
      b.frame0 = 16'h9A6B;
      b.req0 = 1;
      wait_gnt(0, 20, ok);
      check("rstmid_gnt0_seen", 80'(ok), 80'(1));
      step(6*CPB+1);
      d0 = n_done;
      rst = 1;
      step(1);
      rst = 0;
      check("rstmid_tx_busy_done", 80'({b.tx, b.busy, b.done}), 80'(3'b100));
      b.frame1 = 16'h1234;
      b.req1 = 1;
      wait_gnt(1, 20, ok);
      check("rstmid_gnt1_seen", 80'(ok), 80'(1));
      step(T+5);
      check("rstmid_done_count", 80'(n_done - d0), 80'(1));
      // long idle
      n0 = g_own.size();
      step(1000);
      check("idle_no_grants", 80'(g_own.size() - n0), 80'(0));
      check("idle_tx_busy", 80'({b.tx, b.busy}), 80'(2'b10));
      // randomized traffic with occasional resets
      rand_mode = 1;
      step(4000);
      rand_mode = 0;
      rst = 0;
      b.req0 = 0;
      b.req1 = 0;
      step(T+5);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single serial `tx` line feeding `receiver` between two frame requesters.
- Each requester supplies an already convolution-coded frame of CODED_MSG_SIZE bits.
- The block arbitrates between requesters (round-robin), latches the granted frame and serializes it.
- Line format on `tx`: a start bit (0), then the data bits LSB first, then a stop bit (1), then a configurable idle guard period. This is the line format `receiver` decodes.

Parameters:
- CLKS_PER_BIT, 3000: clk cycles per line bit (30 us at 10 ns clk).
- STEP, 0: convolution step, must match `receiver`.
- MSG_SIZE, 6: uncoded message width, must match `receiver`.
- CODED_MSG_SIZE, 2*(MSG_SIZE+2*(2*STEP+1)) (=16 at defaults): frame width. Derived localparam, not overridable.
- GUARD_BITS, 2: idle bit periods with `tx`=1 after each stop bit, before the next grant.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 frame pending; level, held until gnt0
- frame0  input  CODED_MSG_SIZE  requester 0 coded frame; sampled on the gnt0 cycle
- req1  input  1  requester 1 frame pending; level, held until gnt1
- frame1  input  CODED_MSG_SIZE  requester 1 coded frame; sampled on the gnt1 cycle
- gnt0  output  1  one-cycle pulse: frame0 captured
- gnt1  output  1  one-cycle pulse: frame1 captured
- busy  output  1  high from grant cycle through end of guard period
- owner  output  1  source of current/last frame (0 or 1)
- done  output  1  one-cycle pulse on the last cycle of the guard period
- tx  output  1  serial line to `receiver`; idles high

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - tx=1; gnt0=gnt1=busy=done=0; owner=0.
  - FSM goes to IDLE; bit counter, cycle counter and shift register clear to 0.
  - Round-robin pointer set to favour requester 0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 on the next cycle. No done pulse.
- FSM states: IDLE, START, DATA, STOP, GUARD.
- IDLE:
  - tx=1.
  - If any req is high, grant one of them:
    - only one req high: grant it;
    - both high: grant the requester not served last (pointer); after reset, requester 0.
  - On the grant cycle: registered gntN=1, shift register <= frameN, owner<=N, pointer<=N, busy<=1, next state START.
  - A req asserted in the same cycle the block returns to IDLE is eligible on that cycle.
- Registered output timing: tx, gnt0/1, busy and done are registered. tx goes 0 on the cycle after the grant cycle and holds 0 for CLKS_PER_BIT cycles.
- Cycle counter: runs 0..CLKS_PER_BIT-1 within each bit. The bit advances when the count reaches CLKS_PER_BIT-1, then the counter wraps to 0.
- START: one bit period of tx=0, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for each bit period; shift right by 1 at each bit boundary.
  - Bit index counts 0..CODED_MSG_SIZE-1.
  - After bit CODED_MSG_SIZE-1 completes, go to STOP.
- STOP: one bit period of tx=1, then go to GUARD.
- GUARD:
  - GUARD_BITS bit periods of tx=1.
  - done=1 on the final cycle of the period; busy drops to 0 on the next cycle; go to IDLE.
  - GUARD_BITS=0: skip GUARD; done is issued on the last STOP cycle instead.
- Requests while not IDLE are ignored (no grant). They must be held by the requester until granted.
- frameN changes after the grant do not affect the frame in flight.
- Frame length on tx: exactly (CODED_MSG_SIZE+2+GUARD_BITS)*CLKS_PER_BIT cycles from the first tx=0 cycle to done.
- Both gnt0 and gnt1 are never high in the same cycle. Each grant yields exactly one done.

Test Plan:
- Setup for all scenarios: CLKS_PER_BIT=4, defaults otherwise.
- Single frame: req0=1 with frame0=16'b0011101110001110 -> gnt0 pulse one cycle; tx: 4 cycles 0, then bits LSB first (0,1,1,1,0,0,0,1,1,1,0,1,1,1,0,0), 4 cycles each; then stop 1 and 8 guard cycles high. done arrives 80 cycles after the first tx=0 cycle. A `receiver` instance (clks-per-bit matched) outputs the decoded 6-bit message.
- Simultaneous requests after reset: req0=req1=1 with frame0=16'hAAAA, frame1=16'h5555 -> gnt0 first, gnt1 after done. tx shows the A-pattern then the 5-pattern; owner goes 0 then 1.
- Fairness: req0 and req1 held continuously for 4 frames -> grant order 0,1,0,1; no back-to-back grant to the same requester.
- Ignore while busy: req1 rises mid-DATA of a requester 0 frame -> no gnt1 until the cycle after requester 0's frame returns to IDLE. The frame0 change mid-frame does not alter the tx bits.
- Reset mid-frame: rst=1 for one cycle during DATA bit 5 -> next cycle tx=1, busy=0, no done. A subsequent req1 is served as a fresh full frame.
- Idle: no requests for 1000 cycles -> tx=1, busy=0, no grants.
